// File: rtl/seq_restoring_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider_if
// Purpose  : start/busy/done handshake and operand/result bundle for the divider
// Revision : 1.0
// ============================================================================
interface seq_restoring_divider_if #(
   parameter int WIDTH = 9
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_restoring_divider
// Purpose  : multi-cycle unsigned restoring divider, one quotient bit per clock
// Revision : 1.0
// ============================================================================
module seq_restoring_divider #(
   parameter int WIDTH = 9,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   seq_restoring_divider_if.slave     bus
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_FIN  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH:0]   r_r;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_by_zero;
   logic             w_busy;
   logic             w_done;

   logic [WIDTH:0]   w_t;
   logic [WIDTH+1:0] w_diff;
   logic             w_borrow;
   logic [WIDTH:0]   w_r_next;
   logic [WIDTH-1:0] w_q_next;
   logic             w_unused;

   // One trial subtraction per step; the extra MSB of the difference is the borrow.
   assign w_t      = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_diff   = {1'b0, w_t} - {2'b00, r_d};
   assign w_borrow = w_diff[WIDTH+1];
   assign w_r_next = w_borrow ? w_t : w_diff[WIDTH:0];
   assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
   // The restored remainder is always below the divisor, so R's top bit never feeds T.
   assign w_unused = r_r[WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE, c_FIN: w_state_next = bus.start ? c_RUN : c_IDLE;
         c_RUN: begin
            if ((r_d == '0) || (r_cnt == CNT_W'(1))) begin
               w_state_next = c_FIN;
            end
         end
         default: w_state_next = c_IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         c_RUN:   w_busy = 1'b1;
         c_FIN:   w_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q           <= '0;
         r_d           <= '0;
         r_r           <= '0;
         r_cnt         <= '0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE, c_FIN: begin
               if (bus.start) begin
                  r_q   <= bus.dividend;
                  r_d   <= bus.divisor;
                  r_r   <= '0;
                  r_cnt <= CNT_W'(WIDTH);
               end
            end
            c_RUN: begin
               if (r_d == '0) begin
                  // No step has run yet, so Q still holds the latched dividend.
                  r_quotient    <= '1;
                  r_remainder   <= r_q;
                  r_div_by_zero <= 1'b1;
                  r_cnt         <= '0;
               end else begin
                  r_q   <= w_q_next;
                  r_r   <= w_r_next;
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1)) begin
                     r_quotient    <= w_q_next;
                     r_remainder   <= w_r_next[WIDTH-1:0];
                     r_div_by_zero <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
